instr_readout: RTL and testbench
================================

Name: instr_readout

Overview:
- Downstream stage of the instruction register.
- On a start command it sweeps `read_pointer` over a contiguous address range and captures each `instruction_word` into a small output FIFO.
- It streams the captured words out on a valid/ready interface, each tagged with its source address.
- Lets the test/consumer side drain register contents under backpressure without managing the read pointer directly.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command pulse; sampled only in IDLE.
- start_addr  input  address_t  first address to read.
- count  input  6  number of words to read, 0..32.
- abort  input  1  synchronous flush/cancel.
- read_pointer  output  address_t  drives the instruction register read address.
- instruction_word  input  instruction_t  combinational read data for `read_pointer` (zero-latency).
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head.
- out_word  output  instruction_t  FIFO head word.
- out_index  output  address_t  address the head word was read from.
- busy  output  1  high in READ or DRAIN.
- done  output  1  one-cycle pulse when a command completes.
- words_read  output  6  words captured by the current/last command.
- mismatch_count  output  6  see Optional Feature.

Behaviour:
- **Reset** (async, reset_n=0):
  - state=IDLE; FIFO emptied; read_pointer=0.
  - out_valid, busy, done = 0; words_read=0; mismatch_count=0.
  - out_word/out_index = 0.
- **FSM states:** IDLE, READ, DRAIN.
- **IDLE:**
  - `start`=1 and `count`>0: latch rd_ptr=start_addr, remaining=count, clear words_read and mismatch_count; next state READ.
  - `start`=1 and `count`=0: done pulses on the next cycle; stay IDLE; nothing read.
- **READ:**
  - read_pointer=rd_ptr.
  - Capture rule: on each edge where the FIFO is not full, or is full with a pop in the same cycle:
    - push {instruction_word, rd_ptr};
    - rd_ptr increments modulo 32 (31 wraps to 0);
    - remaining decrements; words_read increments.
  - When the FIFO is full and there is no pop, the capture is stalled and read_pointer holds.
  - After the capture that makes remaining=0, next state is DRAIN.
- **DRAIN:** when the FIFO is empty, done=1 for one cycle; next state IDLE.
- **start while busy:** ignored; no side effects.
- **abort (any state):**
  - FIFO flushed on the next edge; state goes to IDLE.
  - done is not pulsed; words_read keeps its value.
  - abort has priority over start and over push.
- **Latency:**
  - start sampled at edge E0.
  - First capture at E1; out_valid=1 after E1.
  - With out_ready held 1 and no stalls, N words take N cycles.
  - done is high in the cycle after the last pop's edge.
- **FIFO:**
  - Registered storage; out_valid = not empty.
  - Transfer when out_valid && out_ready; out_ready while empty has no effect.
  - Simultaneous push and pop are legal at any occupancy, including full and empty. When empty, the pushed word appears at the head on the next cycle; there is no bypass.
  - out_word/out_index hold their value while out_valid && !out_ready.
- **Hold values:** read_pointer holds its last value in IDLE/DRAIN. words_read saturates at 32 by construction.

Optional Feature:
- **Macro:** RESULT_CHECK_EN.
- **When defined:** each captured word's result field is compared with an expected value computed from its opc/op_a/op_b:
  - ZERO → 0; PASSA → a; PASSB → b.
  - ADD → a+b; SUB → a-b; MULT → a*b.
  - DIV / MOD → a/b or a%b; when b=0 → 0.
  - POW → a**b; when b=0 → 1.
  - Any other opcode → no compare.
- On each mismatch, mismatch_count increments (saturates at 63). It is cleared by an accepted start with count>0 and by reset.
- **When undefined:** no check logic is present; mismatch_count is constant 0.

Test Plan:
1. Reset mid-READ (count=8, after 3 captures) → next cycle out_valid=0, busy=0, read_pointer=0, words_read=0, state IDLE.
2. start, start_addr=0, count=4, out_ready=1, register holds ADD 5,3→8 at addr 0..3 → 4 words, out_index 0,1,2,3 on consecutive cycles, first out_valid 1 cycle after start edge, done once, words_read=4.
3. start_addr=30, count=4 → out_index sequence 30,31,0,1.
4. count=8, out_ready=0 for 10 cycles then 1 → exactly FIFO_DEPTH (4) captures, then read_pointer frozen at start_addr+4; all 8 words delivered in order, no loss or duplication.
5. count=0 → done pulse next cycle, busy never 1, out_valid stays 0; abort after 2 captures of count=6 → FIFO empty next cycle, no done, words_read=2.
6. RESULT_CHECK_EN defined, word at addr 5 = DIV a=7 b=0 result=0 and addr 6 = SUB 9,4 result=6 → mismatch_count=1 after command.

Source files
------------

// File: rtl/instr_readout.sv
// instr_readout: sweeps the instruction register read pointer over a
// contiguous address range, buffers each word with its source address in a
// small FIFO and streams the entries out on a valid/ready interface.
// Optional build macro: RESULT_CHECK_EN. When defined, each captured word's
// result field is checked against a value recomputed from opc/op_a/op_b
// and mismatches are counted. When undefined, mismatch_count is tied to 0.

package instr_readout_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int OPC_W  = 4;

  typedef logic [ADDR_W-1:0] address_t;

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [RES_W-1:0]  result;
  } instruction_t;

  localparam logic [OPC_W-1:0] OPC_ZERO  = 4'd0;
  localparam logic [OPC_W-1:0] OPC_PASSA = 4'd1;
  localparam logic [OPC_W-1:0] OPC_PASSB = 4'd2;
  localparam logic [OPC_W-1:0] OPC_ADD   = 4'd3;
  localparam logic [OPC_W-1:0] OPC_SUB   = 4'd4;
  localparam logic [OPC_W-1:0] OPC_MULT  = 4'd5;
  localparam logic [OPC_W-1:0] OPC_DIV   = 4'd6;
  localparam logic [OPC_W-1:0] OPC_MOD   = 4'd7;
  localparam logic [OPC_W-1:0] OPC_POW   = 4'd8;
endpackage

module instr_readout
  import instr_readout_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     start_addr,
  input  logic [5:0]   count,
  input  logic         abort,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         out_valid,
  input  logic         out_ready,
  output instruction_t out_word,
  output address_t     out_index,
  output logic         busy,
  output logic         done,
  output logic [5:0]   words_read,
  output logic [5:0]   mismatch_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_e;

  typedef struct packed {
    instruction_t word;
    address_t     addr;
  } entry_t;

  state_e           state_q, state_d;
  address_t         rd_ptr_q, rd_ptr_d;
  logic [5:0]       remaining_q, remaining_d;
  logic [5:0]       words_q, words_d;
  logic             done_q, done_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  entry_t           mem_q [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic start_go;
  logic start_zero;

  // A full FIFO can still accept a capture when the head leaves in the
  // same cycle; abort overrides both the capture and any start.
  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == FULL_CNT);
  assign pop        = !fifo_empty && out_ready;
  assign push       = (state_q == S_READ) && !abort && (!fifo_full || pop);
  assign start_go   = (state_q == S_IDLE) && start && !abort && (count != 6'd0);
  assign start_zero = (state_q == S_IDLE) && start && !abort && (count == 6'd0);

  // Command sequencing: latch the range on start, advance per capture.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d     = S_READ;
          rd_ptr_d    = start_addr;
          remaining_d = count;
          words_d     = '0;
        end
      end
      S_READ: begin
        if (push) begin
          rd_ptr_d    = rd_ptr_q + 1'b1;
          remaining_d = remaining_q - 6'd1;
          words_d     = words_q + 6'd1;
          if (remaining_q == 6'd1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  // FIFO pointer/occupancy update; abort empties the FIFO outright.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    fcnt_d = fcnt_q;
    if (abort) begin
      head_d = '0;
      tail_d = '0;
      fcnt_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   fcnt_d = fcnt_q + 1'b1;
        2'b01:   fcnt_d = fcnt_q - 1'b1;
        default: fcnt_d = fcnt_q;
      endcase
    end
  end

  // done is registered so it lands in the cycle the drained FIFO is empty,
  // or the cycle after a zero-length start.
  assign done_d = ((state_d == S_DRAIN) && (fcnt_d == '0)) || start_zero;

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      done_q      <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
      done_q      <= done_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fcnt_q      <= fcnt_d;
    end
  end

  // FIFO storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= {instruction_word, rd_ptr_q};
    end
  end

  // Head fields read as zero while empty so they are defined out of reset.
  assign out_valid    = !fifo_empty;
  assign out_word     = fifo_empty ? '0 : mem_q[head_q].word;
  assign out_index    = fifo_empty ? '0 : mem_q[head_q].addr;
  assign read_pointer = rd_ptr_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign words_read   = words_q;

`ifdef RESULT_CHECK_EN
  // Exponentiation by squaring; wraps modulo 2**RES_W like the result field.
  function automatic logic [RES_W-1:0] pow_wrap(input logic [DATA_W-1:0] base,
                                                input logic [DATA_W-1:0] expo);
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] sq;
    acc = RES_W'(1);
    sq  = RES_W'(base);
    for (int i = 0; i < DATA_W; i++) begin
      if (expo[i]) begin
        acc = acc * sq;
      end
      sq = sq * sq;
    end
    return acc;
  endfunction

  function automatic logic check_applies(input logic [OPC_W-1:0] opc);
    return (opc <= OPC_POW);
  endfunction

  function automatic logic [RES_W-1:0] expected_result(input instruction_t w);
    logic [RES_W-1:0] a;
    logic [RES_W-1:0] b;
    logic [RES_W-1:0] r;
    a = RES_W'(w.op_a);
    b = RES_W'(w.op_b);
    case (w.opc)
      OPC_ZERO:  r = '0;
      OPC_PASSA: r = a;
      OPC_PASSB: r = b;
      OPC_ADD:   r = a + b;
      OPC_SUB:   r = a - b;
      OPC_MULT:  r = a * b;
      OPC_DIV:   r = (b == '0) ? '0 : a / b;
      OPC_MOD:   r = (b == '0) ? '0 : a % b;
      OPC_POW:   r = pow_wrap(w.op_a, w.op_b);
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  logic [5:0] mism_q, mism_d;

  // Count captured words whose stored result disagrees with the recomputed one.
  always_comb begin
    mism_d = mism_q;
    if (start_go) begin
      mism_d = '0;
    end else if (push && check_applies(instruction_word.opc) &&
                 (instruction_word.result != expected_result(instruction_word))) begin
      mism_d = sat_inc6(mism_q);
    end
  end

  // Mismatch counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mism_q <= '0;
    end else begin
      mism_q <= mism_d;
    end
  end

  assign mismatch_count = mism_q;
`else
  assign mismatch_count = '0;
`endif

endmodule

// File: tb/tb_instr_readout.sv
// Self-checking bench for instr_readout: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_instr_readout;
  import instr_readout_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic         clk;
  logic         reset_n;
  logic         start;
  address_t     start_addr;
  logic [5:0]   count;
  logic         abort;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         out_valid;
  logic         out_ready;
  instruction_t out_word;
  address_t     out_index;
  logic         busy;
  logic         done;
  logic [5:0]   words_read;
  logic [5:0]   mismatch_count;

  instruction_t reg_mem [32];
  int checks;
  int errors;
  int got[$];
  int exp3 [4];

  instr_readout #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_addr       (start_addr),
    .count            (count),
    .abort            (abort),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_word         (out_word),
    .out_index        (out_index),
    .busy             (busy),
    .done             (done),
    .words_read       (words_read),
    .mismatch_count   (mismatch_count)
  );

  // zero-latency instruction register
  assign instruction_word = reg_mem[read_pointer];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_result(input instruction_t w);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'(w.op_a);
    b = 16'(w.op_b);
    case (w.opc)
      4'd0: return 16'd0;
      4'd1: return a;
      4'd2: return b;
      4'd3: return a + b;
      4'd4: return a - b;
      4'd5: return a * b;
      4'd6: return (b == 16'd0) ? 16'd0 : a / b;
      4'd7: return (b == 16'd0) ? 16'd0 : a % b;
      4'd8: return a ** b;
      default: return w.result;
    endcase
  endfunction

  function automatic instruction_t rand_instr();
    instruction_t w;
    w.opc  = 4'($urandom_range(0, 11));
    w.op_a = 8'($urandom_range(0, 255));
    w.op_b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
    w.result = 16'($urandom_range(0, 65535));
    if ($urandom_range(0, 1) == 0) w.result = ref_result(w);
    return w;
  endfunction

  typedef struct packed {
    instruction_t w;
    address_t     a;
  } ent_t;

  ent_t     mq[$];
  int       m_mode;   // 0 idle, 1 reading, 2 draining
  int       m_total;
  int       m_taken;
  address_t m_ptr;
  int       m_words;
  int       m_mism;
  logic     m_done;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_mode = 0; m_total = 0; m_taken = 0; m_ptr = '0;
      m_words = 0; m_mism = 0; m_done = 1'b0;
    end else begin
      bit was_empty;
      bit do_pop;
      bit cap;
      was_empty = (mq.size() == 0);
      do_pop = !was_empty && out_ready;
      m_done = 1'b0;
      if (abort) begin
        mq.delete();
        m_mode = 0;
      end else begin
        cap = (m_mode == 1) && ((mq.size() < FIFO_DEPTH) || do_pop);
        if (do_pop) void'(mq.pop_front());
        if (m_mode == 0 && start) begin
          if (count == 6'd0) m_done = 1'b1;
          else begin
            m_mode = 1; m_ptr = start_addr; m_total = int'(count);
            m_taken = 0; m_words = 0; m_mism = 0;
          end
        end else if (cap) begin
          mq.push_back({reg_mem[m_ptr], m_ptr});
`ifdef RESULT_CHECK_EN
          if (ref_result(reg_mem[m_ptr]) != reg_mem[m_ptr].result && m_mism < 63) m_mism++;
`endif
          m_taken++;
          m_words++;
          m_ptr = m_ptr + 5'd1;
          if (m_taken == m_total) m_mode = 2;
        end else if (m_mode == 2 && was_empty) begin
          m_mode = 0;
        end
        if (m_mode == 2 && mq.size() == 0) m_done = 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_word", 64'(out_word), 64'(mq[0].w));
      chk("out_index", 64'(out_index), 64'(mq[0].a));
    end
    chk("read_pointer", 64'(read_pointer), 64'(m_ptr));
    chk("busy", 64'(busy), 64'(m_mode != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("words_read", 64'(words_read), 64'(m_words));
    chk("mismatch_count", 64'(mismatch_count), 64'(m_mism));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_model();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s timeout actual=busy required=idle", nm);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start_addr = '0; count = '0;
    exp3[0] = 30; exp3[1] = 31; exp3[2] = 0; exp3[3] = 1;
    for (int i = 0; i < 32; i++) reg_mem[i] = rand_instr();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_words", 64'(words_read), 64'd0);
    chk("rst_mism", 64'(mismatch_count), 64'd0);
    chk("rst_rp", 64'(read_pointer), 64'd0);
    chk("rst_out_word", 64'(out_word), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    reset_n = 1'b1;
    tick();

    // reset in the middle of a read
    out_ready = 1'b0; start = 1'b1; start_addr = 5'd10; count = 6'd8;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("t1_words_before", 64'(words_read), 64'd3);
    chk("t1_rp_before", 64'(read_pointer), 64'd13);
    reset_n = 1'b0;
    #1;
    chk("t1_out_valid", 64'(out_valid), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_rp", 64'(read_pointer), 64'd0);
    chk("t1_words", 64'(words_read), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // straight read of four ADD 5,3 -> 8 words
    for (int i = 0; i < 4; i++) reg_mem[i] = '{opc: OPC_ADD, op_a: 8'd5, op_b: 8'd3, result: 16'd8};
    out_ready = 1'b1; start = 1'b1; start_addr = 5'd0; count = 6'd4;
    tick();
    start = 1'b0;
    chk("t2_valid_e0", 64'(out_valid), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_index", 64'(out_index), 64'(k));
      chk("t2_result", 64'(out_word.result), 64'd8);
    end
    tick();
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_empty", 64'(out_valid), 64'd0);
    chk("t2_words", 64'(words_read), 64'd4);
    tick();
    chk("t2_done_once", 64'(done), 64'd0);
    chk("t2_idle", 64'(busy), 64'd0);

    // address wrap 30,31,0,1
    start = 1'b1; start_addr = 5'd30; count = 6'd4;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_index", 64'(out_index), 64'(exp3[k]));
    end
    wait_idle("t3");
    tick();

    // backpressure: capture stalls at FIFO_DEPTH
    out_ready = 1'b0; start = 1'b1; start_addr = 5'd7; count = 6'd8;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("t4_rp_frozen", 64'(read_pointer), 64'd11);
    chk("t4_words", 64'(words_read), 64'd4);
    chk("t4_head", 64'(out_index), 64'd7);
    out_ready = 1'b1;
    got.delete();
    begin
      int n;
      n = 0;
      while (busy && n < 40) begin
        if (out_valid) got.push_back(int'(out_index));
        tick();
        n++;
      end
    end
    chk("t4_delivered", 64'(got.size()), 64'd8);
    for (int k = 0; k < got.size() && k < 8; k++) chk("t4_order", 64'(got[k]), 64'(7 + k));
    tick();

    // zero-length command
    start = 1'b1; start_addr = 5'd9; count = 6'd0;
    tick();
    start = 1'b0;
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    tick();
    chk("t5_done_once", 64'(done), 64'd0);

    // abort after two captures
    out_ready = 1'b0; start = 1'b1; start_addr = 5'd3; count = 6'd6;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("t5_words_pre", 64'(words_read), 64'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_valid", 64'(out_valid), 64'd0);
    chk("t5_abort_busy", 64'(busy), 64'd0);
    chk("t5_abort_done", 64'(done), 64'd0);
    chk("t5_abort_words", 64'(words_read), 64'd2);
    tick();
    chk("t5_abort_nodone", 64'(done), 64'd0);

    // result checking: DIV by zero is correct, SUB 9-4=6 is wrong
    reg_mem[5] = '{opc: OPC_DIV, op_a: 8'd7, op_b: 8'd0, result: 16'd0};
    reg_mem[6] = '{opc: OPC_SUB, op_a: 8'd9, op_b: 8'd4, result: 16'd6};
    out_ready = 1'b1; start = 1'b1; start_addr = 5'd5; count = 6'd2;
    tick();
    start = 1'b0;
    wait_idle("t6");
`ifdef RESULT_CHECK_EN
    chk("t6_mismatch", 64'(mismatch_count), 64'd1);
`else
    chk("t6_mismatch", 64'(mismatch_count), 64'd0);
`endif
    tick();

    // random traffic
    for (int i = 0; i < 32; i++) reg_mem[i] = rand_instr();
    for (int c = 0; c < 600; c++) begin
      start      = ($urandom_range(0, 5) == 0);
      start_addr = 5'($urandom_range(0, 31));
      count      = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 32));
      out_ready  = ($urandom_range(0, 9) < 7);
      abort      = ($urandom_range(0, 59) == 0);
      reset_n    = (c != 300);
      tick();
    end
    start = 1'b0; abort = 1'b0; reset_n = 1'b1; out_ready = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
